// File: rtl/reg_dump_reader_pkg.sv
// Shared register-file constants and dump FSM state encodings for the register dump reader.
package reg_dump_reader_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_CSUM = 2'd3
  } state_e;
endpackage

// File: rtl/reg_dump_addr_ctr.sv
// Wrapping dump address counter: latches the range on load, steps cur and flags cur==last.
module reg_dump_addr_ctr #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W-1:0] i_last,
  output logic [ADDR_W-1:0] o_cur,
  output logic [ADDR_W-1:0] o_last,
  output logic              o_is_last
);
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_last;

  // Increment wraps naturally at 2**ADDR_W, so first>last walks through the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= '0;
      r_last <= '0;
    end else if (i_load) begin
      r_cur  <= i_first;
      r_last <= i_last;
    end else if (i_inc) begin
      r_cur  <= r_cur + 1'b1;
    end
  end

  assign o_cur     = r_cur;
  assign o_last    = r_last;
  assign o_is_last = (r_cur == r_last);
endmodule

// File: rtl/reg_dump_reader.sv
// Register-file dump initiator: walks an address range and streams values over valid/ready.
// Optional trailing XOR checksum beat enabled by defining REG_DUMP_CHECKSUM_EN.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk_Regs,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] R_Addr,
  input  logic [DATA_W-1:0] R_Data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              dump_is_csum,
  output logic              busy,
  output logic              done
);
  state_e            r_state, w_next;
  logic              w_load, w_inc, w_hs, w_is_last;
  logic [ADDR_W-1:0] w_cur, w_last;

  reg_dump_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk       (clk_Regs),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_inc     (w_inc),
    .i_first   (first_addr),
    .i_last    (last_addr),
    .o_cur     (w_cur),
    .o_last    (w_last),
    .o_is_last (w_is_last)
  );

  assign w_hs   = dump_valid & dump_ready;
  assign R_Addr = w_cur;
  assign busy   = (r_state != ST_IDLE);

  always_ff @(posedge clk_Regs or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_inc  = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_next = ST_READ;
        w_load = 1'b1;
      end
      ST_READ: w_next = abort ? ST_IDLE : ST_SEND;
      ST_SEND: begin
        if (abort) w_next = ST_IDLE;
        else if (w_hs) begin
          if (!w_is_last) begin
            w_inc  = 1'b1;
            w_next = ST_READ;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            w_next = ST_CSUM;
`else
            w_next = ST_IDLE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_CSUM: if (abort || w_hs) w_next = ST_IDLE;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              r_is_csum;
  assign dump_is_csum = r_is_csum;
`else
  assign dump_is_csum = 1'b0;
`endif

  always_ff @(posedge clk_Regs or negedge rst_n) begin
    if (!rst_n) begin
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum     <= '0;
      r_is_csum  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          dump_valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          if (start) r_csum <= '0;
`endif
        end
        ST_READ: if (!abort) begin
          // Snapshot the combinational read so later writes cannot disturb the beat.
          dump_data  <= R_Data;
          dump_addr  <= w_cur;
          dump_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          dump_last  <= 1'b0;
`else
          dump_last  <= w_is_last;
`endif
        end
        ST_SEND: begin
          if (abort) dump_valid <= 1'b0;
          else if (w_hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum <= r_csum ^ dump_data;
            if (!w_is_last) dump_valid <= 1'b0;
            else begin
              dump_data <= r_csum ^ dump_data;
              dump_addr <= w_last;
              dump_last <= 1'b1;
              r_is_csum <= 1'b1;
            end
`else
            dump_valid <= 1'b0;
            if (w_is_last) done <= 1'b1;
`endif
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM: if (abort || w_hs) begin
          dump_valid <= 1'b0;
          r_is_csum  <= 1'b0;
          done       <= ~abort;
        end
`endif
        default: dump_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader; model register file holds reg[i]=A000_0000+i.
module tb_reg_dump_reader;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk_Regs = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, dump_ready = 1'b0;
  logic [4:0]  first_addr = '0, last_addr = '0, R_Addr, dump_addr;
  logic [31:0] R_Data, dump_data;
  logic        dump_valid, dump_last, dump_is_csum, busy, done;
  logic [31:0] rf [32];

  int n_cmp = 0, n_err = 0;

  logic [31:0] e_data[$], o_data[$];
  logic [4:0]  e_addr[$], o_addr[$];
  logic        e_last[$], o_last[$], e_cs[$], o_cs[$];
  bit          got_done;
  int          done_gap, first_vld, stab_err;

  always #5 clk_Regs = ~clk_Regs;
  assign R_Data = rf[R_Addr];

  reg_dump_reader dut (
    .clk_Regs(clk_Regs), .rst_n(rst_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr), .R_Addr(R_Addr), .R_Data(R_Data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_addr(dump_addr), .dump_last(dump_last), .dump_is_csum(dump_is_csum),
    .busy(busy), .done(done)
  );

  function automatic void build_exp(input logic [4:0] f, input logic [4:0] l);
    int n;
    logic [4:0] a;
    logic [31:0] cs;
    e_data.delete(); e_addr.delete(); e_last.delete(); e_cs.delete();
    n = ((int'(l) - int'(f) + 32) % 32) + 1;
    cs = '0;
    for (int i = 0; i < n; i++) begin
      a = f + 5'(i);
      cs ^= 32'hA000_0000 + 32'(a);
      e_data.push_back(32'hA000_0000 + 32'(a));
      e_addr.push_back(a);
      e_last.push_back((i == n - 1) && !CSUM_ON);
      e_cs.push_back(1'b0);
    end
    if (CSUM_ON) begin
      e_data.push_back(cs); e_addr.push_back(l); e_last.push_back(1'b1); e_cs.push_back(1'b1);
    end
  endfunction

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk_Regs);
    first_addr = f; last_addr = l; start = 1'b1;
    @(negedge clk_Regs);
    start = 1'b0;
  endtask

  // Runs the sink until done or the bound expires; bp enables random stalls up to 5 cycles.
  task automatic collect(input bit bp, input int bound);
    int srun, last_hs;
    bit stalled;
    logic [31:0] hd;
    logic [4:0] ha;
    logic hl;
    o_data.delete(); o_addr.delete(); o_last.delete(); o_cs.delete();
    got_done = 0; done_gap = -1; first_vld = -1; stab_err = 0;
    srun = 0; last_hs = -100; stalled = 0; hd = '0; ha = '0; hl = 1'b0;
    for (int cyc = 0; cyc < bound; cyc++) begin
      if (done) begin
        got_done = 1; done_gap = cyc - last_hs;
        break;
      end
      dump_ready = !bp || srun >= 5 || ($urandom_range(0, 2) == 0);
      if (dump_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (stalled && {dump_data, dump_addr, dump_last} !== {hd, ha, hl}) stab_err++;
        if (dump_ready) begin
          o_data.push_back(dump_data); o_addr.push_back(dump_addr);
          o_last.push_back(dump_last); o_cs.push_back(dump_is_csum);
          last_hs = cyc; stalled = 0; srun = 0;
        end else begin
          hd = dump_data; ha = dump_addr; hl = dump_last; stalled = 1; srun++;
        end
      end
      @(negedge clk_Regs);
    end
    dump_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_Regs);
    n_cmp++;
    if ({dump_valid, dump_last, dump_is_csum, busy, done, dump_data, dump_addr, R_Addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v%b l%b c%b b%b d%b data=%h a=%0d ra=%0d want all 0",
               dump_valid, dump_last, dump_is_csum, busy, done, dump_data, dump_addr, R_Addr);
    end
    rst_n = 1'b1;
    @(negedge clk_Regs);
  endtask

  task automatic test_range;
    logic [4:0] tf [3] = '{5'd0, 5'd30, 5'd7};
    logic [4:0] tl [3] = '{5'd31, 5'd1, 5'd7};
    for (int t = 0; t < 3; t++) begin
      do_start(tf[t], tl[t]);
      n_cmp++;
      if ({dump_valid, busy} !== 2'b01) begin
        n_err++; $display("FAIL range%0d_read_state got v%b b%b want v0 b1", t, dump_valid, busy);
      end
      build_exp(tf[t], tl[t]);
      collect(1'b0, 200);
      n_cmp++;
      if (first_vld !== 1) begin
        n_err++; $display("FAIL range%0d_first_valid got cyc %0d want 1", t, first_vld);
      end
      n_cmp++;
      if (!got_done || done_gap !== 1) begin
        n_err++; $display("FAIL range%0d_done got done=%0d gap=%0d want 1/1", t, got_done, done_gap);
      end
      n_cmp++;
      if (o_addr.size() !== e_addr.size()) begin
        n_err++; $display("FAIL range%0d_count got %0d want %0d", t, o_addr.size(), e_addr.size());
      end
      for (int i = 0; i < e_addr.size() && i < o_addr.size(); i++) begin
        n_cmp++;
        if ({o_data[i], o_addr[i], o_last[i], o_cs[i]} !== {e_data[i], e_addr[i], e_last[i], e_cs[i]}) begin
          n_err++;
          $display("FAIL range%0d_beat%0d got %h/%0d/%b/%b want %h/%0d/%b/%b", t, i,
                   o_data[i], o_addr[i], o_last[i], o_cs[i], e_data[i], e_addr[i], e_last[i], e_cs[i]);
        end
      end
      @(negedge clk_Regs);
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_err++; $display("FAIL range%0d_after got done=%b busy=%b want 0 0", t, done, busy);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [4:0] tf [2] = '{5'd0, 5'd27};
    logic [4:0] tl [2] = '{5'd31, 5'd3};
    for (int t = 0; t < 2; t++) begin
      do_start(tf[t], tl[t]);
      build_exp(tf[t], tl[t]);
      collect(1'b1, 2000);
      n_cmp++;
      if (stab_err !== 0 || !got_done) begin
        n_err++; $display("FAIL bp%0d_stable got unstable=%0d done=%0d want 0/1", t, stab_err, got_done);
      end
      n_cmp++;
      if (o_addr.size() !== e_addr.size()) begin
        n_err++; $display("FAIL bp%0d_count got %0d want %0d", t, o_addr.size(), e_addr.size());
      end
      for (int i = 0; i < e_addr.size() && i < o_addr.size(); i++) begin
        n_cmp++;
        if ({o_data[i], o_addr[i], o_last[i], o_cs[i]} !== {e_data[i], e_addr[i], e_last[i], e_cs[i]}) begin
          n_err++;
          $display("FAIL bp%0d_beat%0d got %h/%0d/%b want %h/%0d/%b", t, i,
                   o_data[i], o_addr[i], o_last[i], e_data[i], e_addr[i], e_last[i]);
        end
      end
    end
  endtask

  task automatic test_snapshot;
    int cnt;
    do_start(5'd9, 5'd9);
    cnt = 0;
    while (!dump_valid && cnt < 10) begin @(negedge clk_Regs); cnt++; end
    rf[9] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk_Regs);
    n_cmp++;
    if ({dump_valid, dump_data} !== {1'b1, 32'hA000_0009}) begin
      n_err++; $display("FAIL snapshot got v%b %h want v1 a0000009", dump_valid, dump_data);
    end
    dump_ready = 1'b1;
    cnt = 0;
    while (busy && cnt < 10) begin @(negedge clk_Regs); cnt++; end
    dump_ready = 1'b0;
    rf[9] = 32'hA000_0009;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL snapshot_drain got busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort;
    int cnt, dcnt;
    do_start(5'd0, 5'd31);
    dump_ready = 1'b1;
    cnt = 0;
    while (!(dump_valid && dump_addr == 5'd2) && cnt < 50) begin @(negedge clk_Regs); cnt++; end
    abort = 1'b1; dump_ready = 1'b0;
    @(negedge clk_Regs);
    abort = 1'b0;
    n_cmp++;
    if (cnt >= 50 || {dump_valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL abort got wait=%0d v%b b%b d%b want v0 b0 d0", cnt, dump_valid, busy, done);
    end
    dcnt = 0;
    repeat (5) begin @(negedge clk_Regs); dcnt += int'(done) + int'(busy); end
    n_cmp++;
    if (dcnt !== 0) begin
      n_err++; $display("FAIL abort_quiet got %0d done/busy cycles want 0", dcnt);
    end
    do_start(5'd0, 5'd31);
    repeat (3) @(negedge clk_Regs);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dump_valid, dump_last, dump_is_csum, busy, done, dump_data, dump_addr, R_Addr} !== '0) begin
      n_err++;
      $display("FAIL midreset got v%b b%b data=%h a=%0d ra=%0d want all 0",
               dump_valid, busy, dump_data, dump_addr, R_Addr);
    end
    @(negedge clk_Regs);
    rst_n = 1'b1;
    @(negedge clk_Regs);
  endtask

  task automatic test_start_busy;
    do_start(5'd4, 5'd6);
    first_addr = 5'd20; last_addr = 5'd25; start = 1'b1;
    @(negedge clk_Regs);
    start = 1'b0;
    build_exp(5'd4, 5'd6);
    collect(1'b0, 200);
    n_cmp++;
    if (o_addr.size() !== e_addr.size() || !got_done) begin
      n_err++; $display("FAIL busy_start_count got %0d done=%0d want %0d", o_addr.size(), got_done, e_addr.size());
    end
    for (int i = 0; i < e_addr.size() && i < o_addr.size(); i++) begin
      n_cmp++;
      if ({o_data[i], o_addr[i]} !== {e_data[i], e_addr[i]}) begin
        n_err++; $display("FAIL busy_start_beat%0d got %h/%0d want %h/%0d", i, o_data[i], o_addr[i], e_data[i], e_addr[i]);
      end
    end
    repeat (2) @(negedge clk_Regs);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL busy_start_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_csum;
    logic [4:0]  tf [2] = '{5'd0, 5'd1};
    logic [31:0] tc [2] = '{32'h0000_0000, 32'hA000_0000};
    int n;
    for (int t = 0; t < 2; t++) begin
      do_start(tf[t], 5'd3);
      collect(1'b1, 500);
      n = 5 - int'(tf[t]);
      n_cmp++;
      if (o_addr.size() !== n || !got_done) begin
        n_err++; $display("FAIL csum%0d_count got %0d done=%0d want %0d", t, o_addr.size(), got_done, n);
      end else begin
        n_cmp++;
        if ({o_data[n-1], o_addr[n-1], o_last[n-1], o_cs[n-1], o_cs[n-2], o_last[n-2]} !== {tc[t], 5'd3, 4'b1100}) begin
          n_err++;
          $display("FAIL csum%0d_beat got %h/%0d/l%b/c%b prev c%b l%b want %h/3/l1/c1 prev c0 l0", t,
                   o_data[n-1], o_addr[n-1], o_last[n-1], o_cs[n-1], o_cs[n-2], o_last[n-2], tc[t]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_range();
    test_backpressure();
    test_snapshot();
    test_abort();
    test_start_busy();
    if (CSUM_ON) test_csum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
